// File: rtl/game_pkg.sv
// Shared encodings and defaults for the snake game blocks: FSM state codes,
// grid size defaults and the movement direction code.
package game_pkg;

    localparam logic [2:0] ST_CLEAR_ENC = 3'd0;
    localparam logic [2:0] ST_IDLE_ENC  = 3'd1;
    localparam logic [2:0] ST_PLAY_ENC  = 3'd2;
    localparam logic [2:0] ST_PAUSE_ENC = 3'd3;
    localparam logic [2:0] ST_OVER_ENC  = 3'd4;

    typedef enum logic [2:0] {
        ST_CLEAR = ST_CLEAR_ENC,
        ST_IDLE  = ST_IDLE_ENC,
        ST_PLAY  = ST_PLAY_ENC,
        ST_PAUSE = ST_PAUSE_ENC,
        ST_OVER  = ST_OVER_ENC
    } game_state_t;

    localparam int unsigned GRID_W_DEF = 40;
    localparam int unsigned GRID_H_DEF = 30;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

endpackage

// File: rtl/game_tick_div.sv
// Programmable-period tick divider: counts while not frozen and emits a
// registered one-cycle tick when the count reaches period-1.
module game_tick_div #(
    parameter int unsigned CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             freeze,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic             terminal;

    // '>=' so a period that shrinks below the running count still terminates.
    assign terminal = (cnt >= period - CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (freeze) begin
            tick <= 1'b0;
        end else if (terminal) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: CLEAR/IDLE/PLAY/PAUSE/OVER FSM, screen clear
// sweep, engine init pulse, movement tick and fruit-driven speed-up.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICK_BASE  = 25_000_000,
    parameter int unsigned TICK_MIN   = 5_000_000,
    parameter int unsigned TICK_DEC   = 2_500_000,
    parameter int unsigned SPEED_STEP = 5,
    parameter int unsigned GRID_W     = GRID_W_DEF,
    parameter int unsigned GRID_H     = GRID_H_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enter_pulse,
    input  logic                      pause_pulse,
    input  logic                      collision,
    input  logic                      score_inc,
    input  logic                      clr_ready,
    output logic                      clr_valid,
    output logic [$clog2(GRID_W)-1:0] clr_x,
    output logic [$clog2(GRID_H)-1:0] clr_y,
    output logic                      engine_init,
    output logic                      tick,
    output logic                      game_active,
    output logic [2:0]                state,
    output logic [3:0]                speed_lvl
);

    localparam int unsigned CNT_W = $clog2(TICK_BASE + 1);
    localparam int unsigned XW    = $clog2(GRID_W);
    localparam int unsigned YW    = $clog2(GRID_H);
    localparam int unsigned FW    = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;

    localparam logic [XW-1:0]    X_LAST = XW'(GRID_W - 1);
    localparam logic [YW-1:0]    Y_LAST = YW'(GRID_H - 1);
    localparam logic [FW-1:0]    F_LAST = FW'(SPEED_STEP - 1);
    localparam logic [CNT_W-1:0] P_BASE = CNT_W'(TICK_BASE);

    game_state_t      state_q, state_nxt;
    logic             auto_start;
    logic             new_game, set_auto;
    logic             clr_fire, score_ok;
    logic [CNT_W-1:0] period;
    logic [FW-1:0]    fruit;

    // Saturating period reduction: never drops below TICK_MIN, never wraps.
    function automatic logic [CNT_W-1:0] next_period(input logic [CNT_W-1:0] p);
        if (32'(p) >= TICK_MIN + TICK_DEC)
            return p - CNT_W'(TICK_DEC);
        else
            return CNT_W'(TICK_MIN);
    endfunction

    assign clr_valid   = (state_q == ST_CLEAR);
    assign game_active = (state_q == ST_PLAY) || (state_q == ST_PAUSE);
    assign state       = state_q;
    assign clr_fire    = clr_valid && clr_ready;
    assign score_ok    = (state_q == ST_PLAY) && score_inc && !collision;

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state_q;
        new_game  = 1'b0;
        set_auto  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (clr_fire && clr_x == X_LAST && clr_y == Y_LAST) begin
                    state_nxt = auto_start ? ST_PLAY : ST_IDLE;
                    new_game  = auto_start;
                end
            end
            ST_IDLE: begin
                if (enter_pulse) begin
                    state_nxt = ST_PLAY;
                    new_game  = 1'b1;
                end
            end
            ST_PLAY: begin
                if (collision)
                    state_nxt = ST_OVER;
                else if (pause_pulse)
                    state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pause_pulse || enter_pulse)
                    state_nxt = ST_PLAY;
            end
            ST_OVER: begin
                if (enter_pulse) begin
                    state_nxt = ST_CLEAR;
                    set_auto  = 1'b1;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            engine_init <= 1'b0;
            auto_start  <= 1'b0;
            clr_x       <= '0;
            clr_y       <= '0;
            period      <= P_BASE;
            fruit       <= '0;
            speed_lvl   <= 4'd0;
        end else begin
            state_q     <= state_nxt;
            engine_init <= new_game;

            if (new_game)
                auto_start <= 1'b0;
            else if (set_auto)
                auto_start <= 1'b1;

            // Raster sweep; the final wrap leaves the address at (0,0).
            if (clr_fire) begin
                if (clr_x == X_LAST) begin
                    clr_x <= '0;
                    clr_y <= (clr_y == Y_LAST) ? '0 : clr_y + 1'b1;
                end else begin
                    clr_x <= clr_x + 1'b1;
                end
            end

            if (new_game) begin
                period    <= P_BASE;
                fruit     <= '0;
                speed_lvl <= 4'd0;
            end else if (score_ok) begin
                if (fruit == F_LAST) begin
                    fruit  <= '0;
                    period <= next_period(period);
                    if (speed_lvl != 4'd15)
                        speed_lvl <= speed_lvl + 4'd1;
                end else begin
                    fruit <= fruit + 1'b1;
                end
            end
        end
    end

    game_tick_div #(
        .CNT_W (CNT_W)
    ) u_tick_div (
        .clk    (clk),
        .rst    (rst),
        .clear  (new_game),
        .freeze ((state_q != ST_PLAY) || collision),
        .period (period),
        .tick   (tick)
    );

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl on a 4x3 grid with a short tick period;
// expected values are hand-derived cycle counts and addresses.
module tb_game_flow_ctrl;

    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enter_pulse, pause_pulse, collision, score_inc, clr_ready;
    logic       clr_valid, engine_init, tick, game_active;
    logic [1:0] clr_x, clr_y;
    logic [2:0] state;
    logic [3:0] speed_lvl;

    int n_checks = 0;
    int n_err    = 0;

    game_flow_ctrl #(
        .TICK_BASE  (10),
        .TICK_MIN   (4),
        .TICK_DEC   (3),
        .SPEED_STEP (2),
        .GRID_W     (4),
        .GRID_H     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enter_pulse (enter_pulse),
        .pause_pulse (pause_pulse),
        .collision   (collision),
        .score_inc   (score_inc),
        .clr_ready   (clr_ready),
        .clr_valid   (clr_valid),
        .clr_x       (clr_x),
        .clr_y       (clr_y),
        .engine_init (engine_init),
        .tick        (tick),
        .game_active (game_active),
        .state       (state),
        .speed_lvl   (speed_lvl)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Steps until tick is seen; returns the number of cycles taken (bounded).
    task automatic next_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 100);
    endtask

    initial begin
        int ex, ey, n, nt;

        rst = 1'b1;
        enter_pulse = 1'b0;
        pause_pulse = 1'b0;
        collision   = 1'b0;
        score_inc   = 1'b0;
        clr_ready   = 1'b0;
        step();
        step();

        check("rst_state", 32'(state), 32'(S_CLEAR));
        check("rst_clr_valid", 32'(clr_valid), 1);
        check("rst_clr_x", 32'(clr_x), 0);
        check("rst_clr_y", 32'(clr_y), 0);
        check("rst_engine_init", 32'(engine_init), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_game_active", 32'(game_active), 0);
        check("rst_speed_lvl", 32'(speed_lvl), 0);

        // Clear sweep with ready toggling, ENTER pulsed mid-sweep.
        rst = 1'b0;
        ex = 0;
        ey = 0;
        n  = 0;
        for (int k = 0; k < 100; k++) begin
            if (state !== S_CLEAR) break;
            check("sweep_valid", 32'(clr_valid), 1);
            check("sweep_addr", 32'({clr_y, clr_x}), 32'(ey * 4 + ex));
            clr_ready   = (k % 2 == 0);
            enter_pulse = (k == 3);
            if (clr_ready) begin
                n++;
                if (ex == 3) begin
                    ex = 0;
                    ey = (ey == 2) ? 0 : ey + 1;
                end else begin
                    ex++;
                end
            end
            step();
            if (k == 3) check("enter_in_clear", 32'(state), 32'(S_CLEAR));
        end
        enter_pulse = 1'b0;
        clr_ready   = 1'b0;
        check("sweep_transfers", 32'(n), 12);
        check("sweep_end_state", 32'(state), 32'(S_IDLE));
        check("sweep_end_valid", 32'(clr_valid), 0);
        check("sweep_end_addr", 32'({clr_y, clr_x}), 0);
        check("idle_inactive", 32'(game_active), 0);
        step();
        check("idle_hold", 32'(state), 32'(S_IDLE));

        // Start and tick.
        enter_pulse = 1'b1;
        step();
        enter_pulse = 1'b0;
        check("start_state", 32'(state), 32'(S_PLAY));
        check("start_init", 32'(engine_init), 1);
        check("start_active", 32'(game_active), 1);
        check("start_speed", 32'(speed_lvl), 0);
        step();
        check("init_one_cycle", 32'(engine_init), 0);
        next_tick(n);
        check("first_tick", 32'(n + 1), 10);
        next_tick(n);
        check("tick_period", 32'(n), 10);

        // ENTER in PLAY ignored, then pause at cnt=5.
        enter_pulse = 1'b1;
        step();
        enter_pulse = 1'b0;
        check("enter_in_play", 32'({state, engine_init}), 32'({S_PLAY, 1'b0}));
        repeat (4) step();
        pause_pulse = 1'b1;
        step();
        pause_pulse = 1'b0;
        check("pause_state", 32'(state), 32'(S_PAUSE));
        check("pause_active", 32'(game_active), 1);
        nt = 0;
        for (int i = 0; i < 50; i++) begin
            score_inc = (i == 10);
            step();
            if (tick === 1'b1) nt++;
        end
        score_inc = 1'b0;
        check("pause_no_ticks", 32'(nt), 0);
        check("pause_hold", 32'(state), 32'(S_PAUSE));
        pause_pulse = 1'b1;
        step();
        pause_pulse = 1'b0;
        check("resume_state", 32'({state, engine_init}), 32'({S_PLAY, 1'b0}));
        next_tick(n);
        check("resume_tick", 32'(n + 1), 5);

        // Speed-up: second fruit lands at cnt=7, period drops to 7 -> early tick.
        score_inc = 1'b1;
        step();
        score_inc = 1'b0;
        check("pause_score_ignored", 32'(speed_lvl), 0);
        repeat (6) step();
        score_inc = 1'b1;
        step();
        score_inc = 1'b0;
        check("speed_lvl_1", 32'(speed_lvl), 1);
        check("no_tick_yet", 32'(tick), 0);
        step();
        check("early_tick", 32'(tick), 1);
        next_tick(n);
        check("period_7", 32'(n), 7);

        for (int p = 0; p < 2; p++) begin
            score_inc = 1'b1;
            step();
            score_inc = 1'b0;
            step();
            score_inc = 1'b1;
            step();
            score_inc = 1'b0;
            check("speed_lvl_step", 32'(speed_lvl), 32'(p + 2));
            next_tick(n);
            check("shrink_tick", 32'(n), 1);
            next_tick(n);
            check("period_4", 32'(n), 4);
        end

        // Resume via ENTER; count frozen at 1.
        pause_pulse = 1'b1;
        step();
        pause_pulse = 1'b0;
        check("pause2_state", 32'(state), 32'(S_PAUSE));
        enter_pulse = 1'b1;
        step();
        enter_pulse = 1'b0;
        check("enter_resume", 32'(state), 32'(S_PLAY));
        next_tick(n);
        check("enter_resume_tick", 32'(n), 3);

        // Collision + pause + terminal count in one cycle.
        repeat (3) step();
        collision   = 1'b1;
        pause_pulse = 1'b1;
        step();
        collision   = 1'b0;
        pause_pulse = 1'b0;
        check("over_state", 32'(state), 32'(S_OVER));
        check("over_tick_suppressed", 32'(tick), 0);
        check("over_inactive", 32'(game_active), 0);
        nt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (tick === 1'b1) nt++;
        end
        check("over_no_ticks", 32'(nt), 0);
        enter_pulse = 1'b1;
        step();
        enter_pulse = 1'b0;
        check("restart_clear", 32'(state), 32'(S_CLEAR));
        check("restart_valid", 32'(clr_valid), 1);
        check("restart_addr", 32'({clr_y, clr_x}), 0);
        clr_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            if (state !== S_CLEAR) break;
            if (clr_valid === 1'b1) n++;
            step();
        end
        check("restart_transfers", 32'(n), 12);
        check("auto_play", 32'(state), 32'(S_PLAY));
        check("auto_init", 32'(engine_init), 1);
        check("auto_speed_reset", 32'(speed_lvl), 0);
        next_tick(n);
        check("auto_period_10", 32'(n), 10);

        // Reset mid-sweep after 5 transfers.
        collision = 1'b1;
        step();
        collision = 1'b0;
        check("over2_state", 32'(state), 32'(S_OVER));
        enter_pulse = 1'b1;
        step();
        enter_pulse = 1'b0;
        repeat (5) step();
        check("pre_reset_addr", 32'({clr_y, clr_x}), 5);
        #1 rst = 1'b1;
        #1;
        check("async_reset_addr", 32'({clr_y, clr_x}), 0);
        check("async_reset_state", 32'(state), 32'(S_CLEAR));
        step();
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            if (state !== S_CLEAR) break;
            if (clr_valid === 1'b1) n++;
            step();
        end
        check("reset_sweep_transfers", 32'(n), 12);
        check("reset_sweep_idle", 32'(state), 32'(S_IDLE));
        check("reset_sweep_no_init", 32'(engine_init), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer. It owns the CLEAR/IDLE/PLAY/PAUSE/OVER state machine and replaces the bare `game_started` latch.

- **Screen clear:** drives a raster clear sweep into the painter's cell-write port over a valid/ready handshake.
- **Engine control:** issues the snake-engine/fruit init pulse and generates the movement `tick`.
- **Speed:** shortens the tick period as fruit is eaten.
- **Placement:** sits between the PS/2 decode (`enter`/pause pulses) and the snake engine/painter, and consumes `collision` and `score_inc` from the engine.

## Interface
Parameters:
- `TICK_BASE`, default 25_000_000: initial tick period in `clk` cycles (0.5 s @ 50 MHz).
- `TICK_MIN`, default 5_000_000: lower bound on the tick period.
- `TICK_DEC`, default 2_500_000: period reduction per speed step.
- `SPEED_STEP`, default 5: fruits per speed step.
- `GRID_W`, default 40: grid width in cells.
- `GRID_H`, default 30: grid height in cells.

Ports:
- `clk`  in  1  system clock; the block uses this one clock only.
- `rst`  in  1  reset, asynchronous, active-high.
- `enter_pulse`  in  1  one-cycle ENTER make.
- `pause_pulse`  in  1  one-cycle P-key make.
- `collision`  in  1  level from the snake engine: self or wall hit.
- `score_inc`  in  1  one-cycle fruit-eaten pulse.
- `clr_ready`  in  1  painter accepts a clear write.
- `clr_valid`  out  1  clear write pending.
- `clr_x`  out  $clog2(GRID_W)  clear cell x.
- `clr_y`  out  $clog2(GRID_H)  clear cell y.
- `engine_init`  out  1  one-cycle re-init pulse to the snake engine and fruit placer.
- `tick`  out  1  one-cycle movement step enable.
- `game_active`  out  1  high in PLAY or PAUSE.
- `state`  out  3  current state encoding.
- `speed_lvl`  out  4  number of speed steps applied, saturating at 15.

## Operation
State encodings: CLEAR=0, IDLE=1, PLAY=2, PAUSE=3, OVER=4.

State transitions:
- **CLEAR:**
  - Asserts `clr_valid`; the transfer happens on `clr_valid && clr_ready`.
  - `clr_x` increments per transfer and wraps at GRID_W-1; on wrap, `clr_y` increments.
  - The address is held stable while `clr_valid` is high and `clr_ready` is low.
  - After the transfer at (GRID_W-1, GRID_H-1) is accepted: go to PLAY if `auto_start` is set, else to IDLE.
  - The address returns to (0,0) on exit.
- **IDLE:** `enter_pulse` goes to PLAY.
- **PLAY:**
  - `collision` goes to OVER. It has priority over pause, tick and score in the same cycle.
  - Otherwise `pause_pulse` goes to PAUSE.
- **PAUSE:** `pause_pulse` or `enter_pulse` goes to PLAY (resume).
- **OVER:** `enter_pulse` sets `auto_start` and goes to CLEAR.

Input qualification:
- `enter_pulse` is ignored in CLEAR and PLAY.
- `pause_pulse` is ignored outside PLAY and PAUSE.
- `score_inc` is ignored outside PLAY.

New-game entry (PLAY entered from IDLE or CLEAR):
- `engine_init` is high in the first PLAY cycle.
- Tick counter cleared, period set to TICK_BASE, fruit counter cleared, `speed_lvl` set to 0, `auto_start` cleared.
- Resume from PAUSE does none of this.

Tick generation:
- Counter `cnt` is width $clog2(TICK_BASE+1). It advances only in PLAY and is frozen in PAUSE.
- When `cnt >= period-1`, `cnt` returns to 0 and `tick` pulses.
- The `>=` compare covers a period that shrinks below the current `cnt`.
- `tick` is suppressed in any cycle where `collision` is high.

Speed-up:
- Each `score_inc` in PLAY increments the fruit counter.
- When the counter reaches SPEED_STEP it returns to 0, and:
  - `period` becomes max(`period`-TICK_DEC, TICK_MIN); subtraction is saturating, with no underflow wrap.
  - `speed_lvl` increments, saturating at 15.

## Timing
- **Reset values:** `state`=CLEAR, `clr_valid`=1, `clr_x`=0, `clr_y`=0, `engine_init`=0, `tick`=0, `game_active`=0, `speed_lvl`=0, `period`=TICK_BASE, `auto_start`=0.
- `clr_valid` and `game_active` are decoded from the state register. All other outputs are registered.
- A clear sweep takes at least GRID_W*GRID_H cycles: 1200 at the defaults, each one accepted.
- Input-to-state latency is 1 cycle. `engine_init` coincides with the first cycle of `state`=PLAY.
- The first `tick` after new-game entry comes `period` cycles after `engine_init`.
- `tick` is registered: it is high in the cycle after `cnt` hits terminal.
- After a resume, the tick continues from the frozen `cnt`.
- `rst` mid-sweep restarts the sweep at (0,0) with `auto_start`=0.

## Structure
- Shared package `game_pkg` holds:
  - state encoding localparams;
  - GRID_W/GRID_H defaults;
  - the 2-bit dir encoding (00 right, 01 left, 10 up, 11 down).
- One sub-module, `game_tick_div`:
  - programmable-period counter with clear and freeze inputs and a `tick` output;
  - the period is loaded as an input.
- The FSM, clear sweep and speed logic stay in `game_flow_ctrl`.

## Test plan
Bench parameters: TICK_BASE=10, TICK_MIN=4, TICK_DEC=3, SPEED_STEP=2, GRID 4x3.

1. **Clear sweep:** deassert `rst` with `clr_ready` toggling 1,0,1,0 → exactly 12 transfers in raster order (0,0)..(3,2); address stable while `clr_ready`=0; then `state`=IDLE, `clr_valid`=0.
2. **Start and tick:** `enter_pulse` in IDLE → `engine_init` for 1 cycle, `state`=PLAY; ticks every 10 cycles; `enter_pulse` during CLEAR has no effect.
3. **Speed-up:** 6 `score_inc` pulses → period 10→7→4→4, `speed_lvl` 1,2,3, tick spacing matches the new period; a pulse while `cnt`=8 after the period drops to 7 gives an immediate tick.
4. **Pause:** `pause_pulse` at `cnt`=5 → no ticks for 50 cycles in PAUSE; on resume the next tick comes 5 cycles later; `score_inc` in PAUSE leaves the fruit counter unchanged.
5. **Collision priority:** `collision`, `pause_pulse` and a terminal `cnt` in the same cycle → `state`=OVER, `tick`=0; `enter_pulse` → CLEAR, 12 transfers, then PLAY directly with `engine_init` and period=10.
6. **Reset mid-sweep:** `rst` after 5 transfers → `clr_x`/`clr_y` return to 0 and the sweep ends in IDLE (`auto_start` cleared).
